// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: pending-call mask, SCAN target selection, arrival detection, door dwell.
// Optional feature macro ELEVATOR_DOOR_DWELL_EN: DWELL lasts DWELL_CYCLES cycles (otherwise 1 cycle).
module elevator_call_scheduler #(
    parameter int unsigned NUM_FLOORS   = 10,
    parameter logic [31:0] DWELL_CYCLES = 32'd5000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [3:0]            current_floor,
    input  logic                  car_idle,
    output logic [3:0]            target_floor,
    output logic                  busy,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int unsigned FW = 4;

    typedef enum logic [1:0] {IDLE, SERVE, DWELL} state_t;

    state_t                state, state_next;
    logic [NUM_FLOORS-1:0] pending_next, cur_hot;
    logic [FW-1:0]         target_next, up_floor, dn_floor;
    logic                  dir_next, busy_next, door_next;
    logic                  up_found, dn_found, cur_valid;

`ifdef ELEVATOR_DOOR_DWELL_EN
    logic [31:0] dwell_cnt, dwell_cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dwell_cnt <= 32'd0;
        else        dwell_cnt <= dwell_cnt_next;
    end
`else
    // Single-cycle dwell: no counter; DWELL_CYCLES is referenced only by this empty scope.
    if (DWELL_CYCLES != 32'd0) begin : g_no_dwell_counter
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            dir_up       <= 1'b1;
            busy         <= 1'b0;
            door_open    <= 1'b0;
        end else begin
            state        <= state_next;
            pending      <= pending_next;
            target_floor <= target_next;
            dir_up       <= dir_next;
            busy         <= busy_next;
            door_open    <= door_next;
        end
    end

    // Priority scans: nearest pending floor above and below the car, plus one-hot of the car floor.
    always_comb begin
        up_found  = 1'b0;
        up_floor  = '0;
        dn_found  = 1'b0;
        dn_floor  = '0;
        cur_hot   = '0;
        cur_valid = (32'(current_floor) < NUM_FLOORS);
        for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
            if (pending[f] && (FW'(f) > current_floor)) begin
                up_found = 1'b1;
                up_floor = FW'(f);
            end
        end
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending[f] && (FW'(f) < current_floor)) begin
                dn_found = 1'b1;
                dn_floor = FW'(f);
            end
            cur_hot[f] = (FW'(f) == current_floor);
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending | call_req;
        target_next  = target_floor;
        dir_next     = dir_up;
`ifdef ELEVATOR_DOOR_DWELL_EN
        dwell_cnt_next = dwell_cnt;
`endif
        if (!cur_valid) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    target_next = current_floor;
                    if (|(pending & cur_hot)) begin
                        pending_next = (pending & ~cur_hot) | call_req;
                        state_next   = DWELL;
`ifdef ELEVATOR_DOOR_DWELL_EN
                        dwell_cnt_next = 32'd0;
`endif
                    end else if (|pending) begin
                        state_next = SERVE;
                        if (dir_up) begin
                            if (up_found) target_next = up_floor;
                            else begin
                                target_next = dn_floor;
                                dir_next    = 1'b0;
                            end
                        end else begin
                            if (dn_found) target_next = dn_floor;
                            else begin
                                target_next = up_floor;
                                dir_next    = 1'b1;
                            end
                        end
                    end
                end
                SERVE: begin
                    // Arrival wins over pickup; pickup only retargets to floors between car and target.
                    if ((current_floor == target_floor) && car_idle) begin
                        pending_next = (pending & ~cur_hot) | call_req;
                        state_next   = DWELL;
`ifdef ELEVATOR_DOOR_DWELL_EN
                        dwell_cnt_next = 32'd0;
`endif
                    end else if (dir_up && up_found && (up_floor < target_floor)) begin
                        target_next = up_floor;
                    end else if (!dir_up && dn_found && (dn_floor > target_floor)) begin
                        target_next = dn_floor;
                    end
                end
                DWELL: begin
                    target_next  = current_floor;
                    pending_next = (pending | call_req) & ~cur_hot;
`ifdef ELEVATOR_DOOR_DWELL_EN
                    if (|(call_req & cur_hot)) begin
                        dwell_cnt_next = 32'd0;
                    end else if (dwell_cnt == (DWELL_CYCLES - 32'd1)) begin
                        dwell_cnt_next = 32'd0;
                        state_next     = IDLE;
                    end else begin
                        dwell_cnt_next = dwell_cnt + 32'd1;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
        busy_next = (state_next == SERVE);
        door_next = (state_next == DWELL);
    end
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed self-checking bench for elevator_call_scheduler (NUM_FLOORS=10).
module tb_elevator_call_scheduler;
    localparam int unsigned NF = 10;
`ifdef ELEVATOR_DOOR_DWELL_EN
    localparam int DW = 8;
`else
    localparam int DW = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] call_req = '0;
    logic [3:0]    current_floor = 4'd0;
    logic          car_idle = 1'b1;
    logic [3:0]    target_floor;
    logic          busy, door_open, dir_up;
    logic [NF-1:0] pending;

    int total = 0;
    int bad   = 0;

    elevator_call_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(32'd8)) dut (
        .clk(clk), .rst_n(rst_n), .call_req(call_req), .current_floor(current_floor),
        .car_idle(car_idle), .target_floor(target_floor), .busy(busy),
        .door_open(door_open), .dir_up(dir_up), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset hold
        repeat (3) tick();
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dir", 32'(dir_up), 32'h1);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_target", 32'(target_floor), 32'h0);
        chk("idle_pending", 32'(pending), 32'h0);
        chk("idle_door", 32'(door_open), 32'h0);

        // Single call to floor 5 from floor 0
        call_req = NF'(1 << 5);
        tick();
        call_req = '0;
        chk("t2_pending", 32'(pending), 32'h020);
        chk("t2_busy_early", 32'(busy), 32'h0);
        tick();
        chk("t2_target", 32'(target_floor), 32'h5);
        chk("t2_busy", 32'(busy), 32'h1);
        current_floor = 4'd5;
        tick();
        chk("t2_cleared", 32'(pending), 32'h0);
        chk("t2_door", 32'(door_open), 32'h1);
        repeat (DW) tick();
        chk("t2_door_closed", 32'(door_open), 32'h0);
        chk("t2_idle_target", 32'(target_floor), 32'h5);

        // Pickup on the way up, then reverse for floor 1
        current_floor = 4'd2;
        call_req = NF'(1 << 7);
        tick();
        call_req = '0;
        tick();
        chk("t3_target7", 32'(target_floor), 32'h7);
        car_idle = 1'b0;
        call_req = NF'((1 << 4) | (1 << 1));
        tick();
        call_req = '0;
        chk("t3_pending", 32'(pending), 32'h092);
        tick();
        chk("t3_retarget4", 32'(target_floor), 32'h4);
        current_floor = 4'd4;
        car_idle = 1'b1;
        tick();
        chk("t3_served4", 32'(pending), 32'h082);
        repeat (DW) tick();
        tick();
        chk("t3_target7b", 32'(target_floor), 32'h7);
        chk("t3_dir_up", 32'(dir_up), 32'h1);
        current_floor = 4'd7;
        tick();
        chk("t3_served7", 32'(pending), 32'h002);
        repeat (DW) tick();
        tick();
        chk("t3_target1", 32'(target_floor), 32'h1);
        chk("t3_dir_down", 32'(dir_up), 32'h0);
        chk("t3_busy", 32'(busy), 32'h1);
        current_floor = 4'd1;
        tick();
        chk("t3_served1", 32'(pending), 32'h0);
        repeat (DW) tick();

        // Same-floor call served in place
        current_floor = 4'd3;
        tick();
        call_req = NF'(1 << 3);
        tick();
        call_req = '0;
        chk("t4_pending", 32'(pending), 32'h008);
        chk("t4_door_pre", 32'(door_open), 32'h0);
        tick();
        chk("t4_door", 32'(door_open), 32'h1);
        chk("t4_cleared", 32'(pending), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_target", 32'(target_floor), 32'h3);
`ifdef ELEVATOR_DOOR_DWELL_EN
        repeat (5) tick();
        call_req = NF'(1 << 3);
        tick();
        call_req = '0;
        chk("t4_repulse_clr", 32'(pending), 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("t4_dwell_hold", 32'(door_open), 32'h1);
            tick();
        end
        chk("t4_dwell_end", 32'(door_open), 32'h0);
`else
        call_req = NF'(1 << 3);
        tick();
        call_req = '0;
        chk("t4_dwell_clr", 32'(pending), 32'h0);
        chk("t4_dwell_end", 32'(door_open), 32'h0);
`endif

        // Asynchronous reset during SERVE
        car_idle = 1'b0;
        call_req = NF'(10'h0F0);
        tick();
        call_req = '0;
        chk("t5_pending", 32'(pending), 32'h0F0);
        tick();
        chk("t5_busy", 32'(busy), 32'h1);
        chk("t5_target", 32'(target_floor), 32'h4);
        chk("t5_dir_flip", 32'(dir_up), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pending", 32'(pending), 32'h0);
        chk("t5_rst_target", 32'(target_floor), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);

        // Invalid floor holds dispatch
        current_floor = 4'd12;
        car_idle = 1'b1;
        tick();
        rst_n = 1'b1;
        call_req = NF'(1 << 2);
        tick();
        call_req = '0;
        repeat (3) tick();
        chk("t6_pending", 32'(pending), 32'h004);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_target", 32'(target_floor), 32'h0);
        chk("t6_door", 32'(door_open), 32'h0);
        current_floor = 4'd2;
        tick();
        chk("t6_valid_door", 32'(door_open), 32'h1);
        chk("t6_valid_clr", 32'(pending), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
